// File: rtl/cv32e40s_glitch_controller.sv
// Fault-injection sequencer: arms one request, waits for a trigger plus a delay,
// then drives exactly one injector enable (random or specific mode) for a fixed duration.
//
// state  | meaning
// IDLE   | ready for a request
// ARMED  | request latched, waiting for trigger
// DELAY  | counting trigger-to-glitch delay
// INJECT | selected injector enable asserted
// DONE   | one-cycle completion pulse
module cv32e40s_glitch_controller #(
  parameter  int unsigned NUM_TARGETS = 4,
  parameter  int unsigned DELAY_W     = 16,
  parameter  int unsigned DUR_W       = 8,
  localparam int unsigned TGT_W       = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [TGT_W-1:0]       cfg_target,
  input  logic [DELAY_W-1:0]     cfg_delay,
  input  logic [DUR_W-1:0]       cfg_duration,
  input  logic                   cfg_specific,
  input  logic                   trigger,
  input  logic                   abort,
  output logic [NUM_TARGETS-1:0] inj_enable,
  output logic [NUM_TARGETS-1:0] inj_enable_specific,
  output logic                   busy,
  output logic                   done,
  output logic [15:0]            glitch_count
);

  localparam int unsigned CNT_W = (DELAY_W > DUR_W) ? DELAY_W : DUR_W;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    DELAY,
    INJECT,
    DONE
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [TGT_W-1:0]     tgt_q;
  logic [DELAY_W-1:0]   delay_q;
  logic [DUR_W-1:0]     dur_q;
  logic                 spec_q;
  logic                 hit_q, hit_d;
  logic                 accept;
  logic                 tgt_valid;
  logic [NUM_TARGETS-1:0] tgt_hot;
  logic [15:0]          count_q;

  // Out-of-range targets decode to no bit at all, which also makes tgt_valid false.
  always_comb begin
    tgt_hot = '0;
    for (int i = 0; i < NUM_TARGETS; i++) begin
      tgt_hot[i] = (tgt_q == TGT_W'(i));
    end
  end

  assign tgt_valid = |tgt_hot;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hit_d   = hit_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cfg_valid) begin
          accept  = 1'b1;
          hit_d   = 1'b0;
          state_d = ARMED;
        end
      end
      ARMED: begin
        if (trigger) begin
          if (dur_q == '0) begin
            state_d = DONE;
          end else if (delay_q == '0) begin
            state_d = INJECT;
            cnt_d   = CNT_W'(dur_q);
            hit_d   = tgt_valid;
          end else begin
            state_d = DELAY;
            cnt_d   = CNT_W'(delay_q);
          end
        end
      end
      DELAY: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = INJECT;
          cnt_d   = CNT_W'(dur_q);
          hit_d   = tgt_valid;
        end
      end
      INJECT: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Abort wins over trigger and counter expiry; it only matters once a request is held.
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hit_q   <= hit_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tgt_q   <= '0;
      delay_q <= '0;
      dur_q   <= '0;
      spec_q  <= 1'b0;
    end else if (accept) begin
      tgt_q   <= cfg_target;
      delay_q <= cfg_delay;
      dur_q   <= cfg_duration;
      spec_q  <= cfg_specific;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if ((state_q == DONE) && hit_q && (count_q != 16'hFFFF)) begin
      count_q <= count_q + 16'd1;
    end
  end

  always_comb begin
    inj_enable          = '0;
    inj_enable_specific = '0;
    if (state_q == INJECT) begin
      if (spec_q) begin
        inj_enable_specific = tgt_hot;
      end else begin
        inj_enable = tgt_hot;
      end
    end
  end

  assign cfg_ready    = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
  assign glitch_count = count_q;

endmodule

// File: tb/tb_cv32e40s_glitch_controller.sv
// Directed bench for the glitch controller; five targets so that indices 5..7 are out of range.
module tb_cv32e40s_glitch_controller;

  localparam int NT = 5;
  localparam int DW = 16;
  localparam int NW = 8;
  localparam int TW = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          cfg_valid;
  logic          cfg_ready;
  logic [TW-1:0] cfg_target;
  logic [DW-1:0] cfg_delay;
  logic [NW-1:0] cfg_duration;
  logic          cfg_specific;
  logic          trigger;
  logic          abort;
  logic [NT-1:0] inj_enable;
  logic [NT-1:0] inj_enable_specific;
  logic          busy;
  logic          done;
  logic [15:0]   glitch_count;

  int n_checks = 0;
  int n_err    = 0;

  cv32e40s_glitch_controller #(
    .NUM_TARGETS(NT),
    .DELAY_W    (DW),
    .DUR_W      (NW)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .cfg_valid          (cfg_valid),
    .cfg_ready          (cfg_ready),
    .cfg_target         (cfg_target),
    .cfg_delay          (cfg_delay),
    .cfg_duration       (cfg_duration),
    .cfg_specific       (cfg_specific),
    .trigger            (trigger),
    .abort              (abort),
    .inj_enable         (inj_enable),
    .inj_enable_specific(inj_enable_specific),
    .busy               (busy),
    .done               (done),
    .glitch_count       (glitch_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // At most one enable bit across both vectors, every cycle outside reset.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      n_checks++;
      assert ($onehot0(inj_enable | inj_enable_specific)) else begin
        n_err++;
        $error("FAIL onehot observed=0x%0h/0x%0h expected=at most one bit", inj_enable, inj_enable_specific);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic request(input int t, input int d, input int n, input bit s);
    cfg_valid    = 1'b1;
    cfg_target   = TW'(t);
    cfg_delay    = DW'(d);
    cfg_duration = NW'(n);
    cfg_specific = s;
    step();
    cfg_valid = 1'b0;
    chk("accept_busy", 32'(busy), 32'd1);
    chk("accept_ready", 32'(cfg_ready), 32'd0);
  endtask

  // Trigger from ARMED and check every cycle up to the first IDLE cycle.
  // With noise, cfg_valid stays high with other values and trigger pulses during DELAY.
  task automatic fire(input int t, input int d, input int n, input bit s, input bit noise,
                      input int exp_cnt);
    int            done_k;
    logic [NT-1:0] hot;
    logic [NT-1:0] exp_r;
    logic [NT-1:0] exp_s;
    bit            win;
    hot    = (t < NT) ? (NT'(1) << t) : '0;
    done_k = (n == 0) ? 1 : d + n + 1;
    if (noise) begin
      cfg_valid    = 1'b1;
      cfg_target   = TW'(t ^ 1);
      cfg_delay    = '0;
      cfg_duration = NW'(1);
      cfg_specific = !s;
    end
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    for (int k = 1; k <= done_k + 1; k++) begin
      win   = (n > 0) && (k > d) && (k <= d + n);
      exp_r = (win && !s) ? hot : '0;
      exp_s = (win && s) ? hot : '0;
      chk("en_random", 32'(inj_enable), 32'(exp_r));
      chk("en_specific", 32'(inj_enable_specific), 32'(exp_s));
      chk("done", 32'(done), 32'(k == done_k));
      chk("busy", 32'(busy), 32'(k <= done_k));
      if (noise) begin
        trigger = (k <= d);
        if (k >= done_k) cfg_valid = 1'b0;
      end
      if (k <= done_k) step();
    end
    chk("ready_after", 32'(cfg_ready), 32'd1);
    chk("count_after", 32'(glitch_count), 32'(exp_cnt));
  endtask

  initial begin
    reset        = 1'b1;
    cfg_valid    = 1'b0;
    cfg_target   = '0;
    cfg_delay    = '0;
    cfg_duration = '0;
    cfg_specific = 1'b0;
    trigger      = 1'b0;
    abort        = 1'b0;
    step();
    step();
    reset = 1'b0;

    chk("rst_ready", 32'(cfg_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_count", 32'(glitch_count), 32'd0);
    chk("rst_en", 32'(inj_enable), 32'd0);
    chk("rst_en_spec", 32'(inj_enable_specific), 32'd0);

    // Random mode, target 2: enable 0b00100 in T+4..T+5, done T+6
    request(2, 3, 2, 1'b0);
    step();
    chk("armed_no_enable", 32'(inj_enable), 32'd0);
    fire(2, 3, 2, 1'b0, 1'b0, 1);

    // Specific mode, zero delay; abort while IDLE must not block acceptance
    abort = 1'b1;
    request(0, 0, 1, 1'b1);
    abort = 1'b0;
    fire(0, 0, 1, 1'b1, 1'b0, 2);

    // Abort during INJECT at T+7
    request(1, 5, 4, 1'b0);
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    repeat (6) step();
    chk("abort_pre_en", 32'(inj_enable), 32'h02);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_en", 32'(inj_enable), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ready", 32'(cfg_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      chk("abort_no_done", 32'(done), 32'd0);
      step();
    end
    chk("abort_count", 32'(glitch_count), 32'd2);

    // Zero duration, then out-of-range target
    request(3, 4, 0, 1'b0);
    fire(3, 4, 0, 1'b0, 1'b0, 2);
    request(5, 1, 2, 1'b0);
    fire(5, 1, 2, 1'b0, 1'b0, 2);

    // cfg_valid held with other values and trigger pulses during DELAY
    request(4, 2, 2, 1'b1);
    fire(4, 2, 2, 1'b1, 1'b1, 3);
    step();
    chk("noise_not_accepted", 32'(busy), 32'd0);

    // Reset in the middle of INJECT
    request(1, 0, 5, 1'b0);
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    chk("pre_reset_en", 32'(inj_enable), 32'h02);
    reset = 1'b1;
    step();
    chk("mid_rst_ready", 32'(cfg_ready), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_en", 32'(inj_enable), 32'd0);
    chk("mid_rst_en_spec", 32'(inj_enable_specific), 32'd0);
    chk("mid_rst_count", 32'(glitch_count), 32'd0);
    reset = 1'b0;
    step();

    // Saturation from a preloaded count
    force dut.count_q = 16'hFFFE;
    step();
    release dut.count_q;
    chk("preload", 32'(glitch_count), 32'hFFFE);
    request(1, 0, 1, 1'b0);
    fire(1, 0, 1, 1'b0, 1'b0, 32'hFFFF);
    request(2, 1, 1, 1'b1);
    fire(2, 1, 1, 1'b1, 1'b0, 32'hFFFF);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
